mmu_req_arbiter: RTL and testbench
==================================

# mmu_req_arbiter

Sequencer and arbiter in front of the single `arm7tdmi_mmu` CPU port. It shares the translation port between the instruction-fetch and data requesters. It serializes TLB maintenance commands (flush all/entry/ASID/global) and ASID changes so they only take effect while no translation is in flight. It sits between the core's fetch/LSU units and the MMU, and owns the `current_asid` register the MMU consumes.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, virtual address width
- `STARVE_LIMIT`, 4, consecutive data grants after which a waiting fetch wins
- `RESET_ASID`, 8'h00, `current_asid` value out of reset

Ports. Reset `rst_n` is asynchronous, active-low; clock `clk`.
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `i_vaddr`  in  ADDR_WIDTH  fetch address
- `i_req`  in  1  fetch request; held until `i_ready` or `i_abort`
- `i_rdata`  out  32  fetch read data
- `i_ready`  out  1  fetch complete
- `i_abort`  out  1  fetch aborted
- `d_vaddr`  in  ADDR_WIDTH  data address
- `d_req`  in  1  data request; held until `d_ready` or `d_abort`
- `d_write`  in  1  data write
- `d_size`  in  2  data size
- `d_wdata`  in  32  write data
- `d_rdata`  out  32  read data
- `d_ready`  out  1  data complete
- `d_abort`  out  1  data aborted
- `maint_valid`  in  1  maintenance command valid; held until `maint_ack`
- `maint_op`  in  3  `mmu_maint_op_e` opcode
- `maint_addr`  in  32  address for FLUSH_ENTRY
- `maint_asid`  in  8  ASID for FLUSH_ASID / SET_ASID
- `maint_ack`  out  1  one-cycle command done
- `maint_err`  out  1  with `maint_ack`: reserved opcode
- `mmu_vaddr`, `mmu_req`, `mmu_write`, `mmu_size`, `mmu_wdata`  out  to MMU `cpu_*`
- `mmu_rdata`, `mmu_ready`, `mmu_abort`  in  from MMU `cpu_*`
- `mmu_busy`  in  1  MMU walk/flush in progress
- `tlb_flush_all`, `tlb_flush_entry`, `tlb_flush_asid`, `tlb_flush_global`  out  1  one-cycle strobes
- `tlb_flush_addr`  out  32  flush address
- `tlb_flush_asid_val`  out  8  flush ASID
- `current_asid`  out  8  registered ASID to MMU
- `stat_i_grants`, `stat_d_grants`, `stat_i_wait`  out  32  statistics (see Configuration)

## Operation
- FSM states:
  - IDLE
  - GRANT_I
  - GRANT_D
  - MAINT_ISSUE
  - MAINT_DRAIN
- Arbitration in IDLE, fixed priority, evaluated in this order:
  1. `maint_valid` && !`mmu_busy` → MAINT_ISSUE.
  2. `i_req` && `starve_cnt` == STARVE_LIMIT → GRANT_I.
  3. `d_req` → GRANT_D.
  4. `i_req` → GRANT_I.
- Maintenance priority is over new grants only. A grant in flight always completes first.
- `starve_cnt`:
  - increments, saturating, on each GRANT_D entry while `i_req` is high
  - clears on GRANT_I entry
- GRANT_x:
  - `mmu_req`=1 and the owner's fields are muxed onto `mmu_*`. Fetch drives `mmu_write`=0 and `mmu_size`=2'b10.
  - The first cycle in GRANT_x is never a completion cycle.
  - From the second cycle on, `mmu_ready|mmu_abort` routes combinationally to the owner's `ready`/`abort`, and `rdata` passes through.
  - The FSM then returns to IDLE. The non-owner sees `ready`=`abort`=0.
- MAINT_ISSUE, one cycle, one action per opcode:
  - FLUSH_ALL / FLUSH_ENTRY / FLUSH_ASID / FLUSH_GLOBAL: pulse the matching `tlb_flush_*` strobe, with `tlb_flush_addr`/`tlb_flush_asid_val` driven from the `maint_*` inputs.
  - SET_ASID: load `current_asid` ← `maint_asid`.
  - Reserved opcode: no strobe.
- MAINT_DRAIN: wait until `mmu_busy`=0, then pulse `maint_ack` (plus `maint_err` for a reserved opcode) and return to IDLE.
- `current_asid` changes only via SET_ASID, hence never while `mmu_req`=1.
- Requester drops `req` mid-grant: protocol violation. The arbiter holds the grant until the MMU completes.

## Timing
- Reset values:
  - all outputs 0, except `current_asid`=RESET_ASID
  - FSM in IDLE, `starve_cnt`=0, statistics 0
- Latency:
  - Request to `mmu_req`: 1 cycle (IDLE→GRANT registered).
  - Completion to next grant: 1 IDLE cycle minimum.
- Maintenance: ack no earlier than 2 cycles after IDLE accepts the command; flush strobes are exactly 1 cycle wide.
- Reset mid-operation:
  - Outputs clear immediately (async), and any pending strobe is dropped.
  - Requesters must re-issue.
- Statistics counters wrap at 2^32.

## Configuration
- `MMU_ARB_STATS_EN` defined:
  - `stat_i_grants`/`stat_d_grants` count GRANT_I/GRANT_D entries.
  - `stat_i_wait` counts cycles with `i_req`=1 and the FSM not in GRANT_I.
- Not defined: the counters are not synthesized and the three outputs are tied to 0.

## Structure
- `arm7tdmi_pkg` gains:
  - `mmu_maint_op_e` (3-bit): FLUSH_ALL=0, FLUSH_ENTRY=1, FLUSH_ASID=2, FLUSH_GLOBAL=3, SET_ASID=4, 5–7 reserved
  - `mmu_arb_state_e`
- One sub-module, `mmu_arb_stats`, holds the counters. It is instantiated only under `MMU_ARB_STATS_EN`.

## Test plan
- Reset → `current_asid`=8'h00, all strobes 0. Then `d_req` to 0x40001000 → one `mmu_req` grant with `mmu_vaddr`=0x40001000; `d_ready` arrives with the MMU ready.
- `i_req` and `d_req` held continuously, STARVE_LIMIT=4 → grant order D,D,D,D,I repeating; `i_ready` never seen more than 5 grants apart.
- SET_ASID 8'h02 issued while a D grant is in flight → `current_asid` stays 8'h01 until after `d_ready`, then becomes 02; `maint_ack` follows.
- FLUSH_ASID 8'h01 → exactly one `tlb_flush_asid` pulse with `tlb_flush_asid_val`=01. With `mmu_busy` held 3 cycles, `maint_ack` is delayed until `mmu_busy` falls.
- `maint_op`=3'd6 → `maint_ack`=1 with `maint_err`=1 and no flush strobe.
- Reset asserted during a GRANT_I → `mmu_req` drops asynchronously and the FSM restarts in IDLE. With `MMU_ARB_STATS_EN`, all stat counters read 0.

Source files
------------

// File: rtl/arm7tdmi_pkg.sv
// rtl/arm7tdmi_pkg.sv - shared ARM7TDMI types: MMU maintenance opcodes and request arbiter states
package arm7tdmi_pkg;

  // Opcodes 5..7 are reserved and acknowledged with maint_err.
  typedef enum logic [2:0] {
    FLUSH_ALL    = 3'd0,
    FLUSH_ENTRY  = 3'd1,
    FLUSH_ASID   = 3'd2,
    FLUSH_GLOBAL = 3'd3,
    SET_ASID     = 3'd4
  } mmu_maint_op_e;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    MAINT_ISSUE,
    MAINT_DRAIN
  } mmu_arb_state_e;

endpackage

// File: rtl/mmu_arb_stats.sv
// rtl/mmu_arb_stats.sv - grant and fetch-wait statistics counters for mmu_req_arbiter
module mmu_arb_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_grant,
  input  logic        d_grant,
  input  logic        i_wait,
  output logic [31:0] i_grants,
  output logic [31:0] d_grants,
  output logic [31:0] i_waits
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_grants <= '0;
      d_grants <= '0;
      i_waits  <= '0;
    end else begin
      if (i_grant) i_grants <= i_grants + 32'd1;
      if (d_grant) d_grants <= d_grants + 32'd1;
      if (i_wait)  i_waits  <= i_waits + 32'd1;
    end
  end

endmodule

// File: rtl/mmu_req_arbiter.sv
// rtl/mmu_req_arbiter.sv - fetch/data arbiter and TLB maintenance sequencer for the MMU CPU port
// Statistics counters are built only when MMU_ARB_STATS_EN is defined.
module mmu_req_arbiter
  import arm7tdmi_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         STARVE_LIMIT = 4,
  parameter logic [7:0] RESET_ASID   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] i_vaddr,
  input  logic                  i_req,
  output logic [31:0]           i_rdata,
  output logic                  i_ready,
  output logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] d_vaddr,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [1:0]            d_size,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_ready,
  output logic                  d_abort,
  input  logic                  maint_valid,
  input  logic [2:0]            maint_op,
  input  logic [31:0]           maint_addr,
  input  logic [7:0]            maint_asid,
  output logic                  maint_ack,
  output logic                  maint_err,
  output logic [ADDR_WIDTH-1:0] mmu_vaddr,
  output logic                  mmu_req,
  output logic                  mmu_write,
  output logic [1:0]            mmu_size,
  output logic [31:0]           mmu_wdata,
  input  logic [31:0]           mmu_rdata,
  input  logic                  mmu_ready,
  input  logic                  mmu_abort,
  input  logic                  mmu_busy,
  output logic                  tlb_flush_all,
  output logic                  tlb_flush_entry,
  output logic                  tlb_flush_asid,
  output logic                  tlb_flush_global,
  output logic [31:0]           tlb_flush_addr,
  output logic [7:0]            tlb_flush_asid_val,
  output logic [7:0]            current_asid,
  output logic [31:0]           stat_i_grants,
  output logic [31:0]           stat_d_grants,
  output logic [31:0]           stat_i_wait
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  mmu_arb_state_e state, state_n;
  logic [SW-1:0]  starve_cnt;
  logic           first;   // first grant cycle: MMU handshake is not yet meaningful
  logic           enter_i, enter_d;

  assign enter_i = (state == IDLE) && (state_n == GRANT_I);
  assign enter_d = (state == IDLE) && (state_n == GRANT_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n            = state;
    mmu_req            = 1'b0;
    mmu_vaddr          = '0;
    mmu_write          = 1'b0;
    mmu_size           = 2'b00;
    mmu_wdata          = '0;
    i_rdata            = '0;
    i_ready            = 1'b0;
    i_abort            = 1'b0;
    d_rdata            = '0;
    d_ready            = 1'b0;
    d_abort            = 1'b0;
    maint_ack          = 1'b0;
    maint_err          = 1'b0;
    tlb_flush_all      = 1'b0;
    tlb_flush_entry    = 1'b0;
    tlb_flush_asid     = 1'b0;
    tlb_flush_global   = 1'b0;
    tlb_flush_addr     = '0;
    tlb_flush_asid_val = '0;
    case (state)
      IDLE: begin
        if (maint_valid && !mmu_busy)             state_n = MAINT_ISSUE;
        else if (i_req && starve_cnt == STARVE_MAX) state_n = GRANT_I;
        else if (d_req)                           state_n = GRANT_D;
        else if (i_req)                           state_n = GRANT_I;
      end
      GRANT_I: begin
        mmu_req   = 1'b1;
        mmu_vaddr = i_vaddr;
        mmu_size  = 2'b10;
        if (!first) begin
          i_rdata = mmu_rdata;
          i_ready = mmu_ready;
          i_abort = mmu_abort;
          if (mmu_ready || mmu_abort) state_n = IDLE;
        end
      end
      GRANT_D: begin
        mmu_req   = 1'b1;
        mmu_vaddr = d_vaddr;
        mmu_write = d_write;
        mmu_size  = d_size;
        mmu_wdata = d_wdata;
        if (!first) begin
          d_rdata = mmu_rdata;
          d_ready = mmu_ready;
          d_abort = mmu_abort;
          if (mmu_ready || mmu_abort) state_n = IDLE;
        end
      end
      MAINT_ISSUE: begin
        tlb_flush_addr     = maint_addr;
        tlb_flush_asid_val = maint_asid;
        case (maint_op)
          FLUSH_ALL:    tlb_flush_all    = 1'b1;
          FLUSH_ENTRY:  tlb_flush_entry  = 1'b1;
          FLUSH_ASID:   tlb_flush_asid   = 1'b1;
          FLUSH_GLOBAL: tlb_flush_global = 1'b1;
          default: ;
        endcase
        state_n = MAINT_DRAIN;
      end
      MAINT_DRAIN: begin
        if (!mmu_busy) begin
          maint_ack = 1'b1;
          maint_err = (maint_op > SET_ASID);
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first        <= 1'b0;
      starve_cnt   <= '0;
      current_asid <= RESET_ASID;
    end else begin
      first <= enter_i || enter_d;
      if (enter_i)
        starve_cnt <= '0;
      else if (enter_d && i_req && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
      // Only loaded from MAINT_ISSUE, so never while a translation is in flight.
      if (state == MAINT_ISSUE && maint_op == SET_ASID)
        current_asid <= maint_asid;
    end
  end

`ifdef MMU_ARB_STATS_EN
  mmu_arb_stats u_stats (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_grant  (enter_i),
    .d_grant  (enter_d),
    .i_wait   (i_req && state != GRANT_I),
    .i_grants (stat_i_grants),
    .d_grants (stat_d_grants),
    .i_waits  (stat_i_wait)
  );
`else
  assign stat_i_grants = '0;
  assign stat_d_grants = '0;
  assign stat_i_wait   = '0;
`endif

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// tb/tb_mmu_req_arbiter.sv - randomized self-checking bench for mmu_req_arbiter
module tb_mmu_req_arbiter;
  import arm7tdmi_pkg::*;

  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_vaddr, i_rdata, d_vaddr, d_wdata, d_rdata, mmu_vaddr, mmu_wdata, mmu_rdata;
  logic [31:0] maint_addr, tlb_flush_addr, stat_i_grants, stat_d_grants, stat_i_wait;
  logic        i_req, i_ready, i_abort, d_req, d_write, d_ready, d_abort;
  logic [1:0]  d_size, mmu_size;
  logic        maint_valid, maint_ack, maint_err;
  logic [2:0]  maint_op;
  logic [7:0]  maint_asid, tlb_flush_asid_val, current_asid;
  logic        mmu_req, mmu_write, mmu_ready, mmu_abort, mmu_busy;
  logic        tlb_flush_all, tlb_flush_entry, tlb_flush_asid, tlb_flush_global;

  int n_tests = 0;
  int n_fail  = 0;
  int lat_min = 0, lat_max = 2, mmu_wait = 0, busy_left = 0;
  bit abort_en = 1'b1;
  int grant_log[$];

  mmu_req_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(SL), .RESET_ASID(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_vaddr(i_vaddr), .i_req(i_req), .i_rdata(i_rdata), .i_ready(i_ready), .i_abort(i_abort),
    .d_vaddr(d_vaddr), .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_abort(d_abort),
    .maint_valid(maint_valid), .maint_op(maint_op), .maint_addr(maint_addr), .maint_asid(maint_asid),
    .maint_ack(maint_ack), .maint_err(maint_err),
    .mmu_vaddr(mmu_vaddr), .mmu_req(mmu_req), .mmu_write(mmu_write), .mmu_size(mmu_size),
    .mmu_wdata(mmu_wdata), .mmu_rdata(mmu_rdata), .mmu_ready(mmu_ready), .mmu_abort(mmu_abort),
    .mmu_busy(mmu_busy),
    .tlb_flush_all(tlb_flush_all), .tlb_flush_entry(tlb_flush_entry), .tlb_flush_asid(tlb_flush_asid),
    .tlb_flush_global(tlb_flush_global), .tlb_flush_addr(tlb_flush_addr),
    .tlb_flush_asid_val(tlb_flush_asid_val), .current_asid(current_asid),
    .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants), .stat_i_wait(stat_i_wait)
  );

  always #5 clk = ~clk;

  // One clock: advance past the edge, then play the MMU side for this cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    mmu_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    mmu_ready = 1'b0;
    mmu_abort = 1'b0;
    if (!mmu_req) mmu_wait = $urandom_range(lat_max, lat_min);
    else if (mmu_wait > 0) mmu_wait--;
    else begin
      mmu_rdata = $urandom;
      if (abort_en && $urandom_range(3, 0) == 0) mmu_abort = 1'b1;
      else mmu_ready = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; maint_valid = 1'b0;
    mmu_ready = 1'b0; mmu_abort = 1'b0; mmu_busy = 1'b0; busy_left = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mmu_rdata = 32'hdead_beef;
    #12;
    n_tests++;
    if ({mmu_req, i_ready, d_ready, i_abort, d_abort, maint_ack, maint_err} !== 7'b0)
      begin n_fail++; $display("FAIL reset_handshake got %b want 0", {mmu_req, i_ready, d_ready, i_abort, d_abort, maint_ack, maint_err}); end
    n_tests++;
    if ({tlb_flush_all, tlb_flush_entry, tlb_flush_asid, tlb_flush_global} !== 4'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0)
      begin n_fail++; $display("FAIL reset_strobes got %b rdata %h/%h want 0", {tlb_flush_all, tlb_flush_entry, tlb_flush_asid, tlb_flush_global}, i_rdata, d_rdata); end
    n_tests++;
    if (current_asid !== 8'h00)
      begin n_fail++; $display("FAIL reset_asid got %h want 00", current_asid); end
    n_tests++;
    if ({stat_i_grants, stat_d_grants, stat_i_wait} !== 96'h0)
      begin n_fail++; $display("FAIL reset_stats got %h %h %h want 0", stat_i_grants, stat_d_grants, stat_i_wait); end
    apply_reset();
  endtask

  task automatic test_single_d();
    int got = -1, grants = 0;
    bit prev = 1'b0;
    apply_reset();
    abort_en = 1'b0; lat_min = 1; lat_max = 1;
    cycle();
    d_req = 1'b1; d_vaddr = 32'h4000_1000; d_write = 1'b0; d_size = 2'b10; d_wdata = 32'h0;
    #1;
    n_tests++;
    if (mmu_req !== 1'b0) begin n_fail++; $display("FAIL single_d_same_cycle got %b want 0", mmu_req); end
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (got >= 0) d_req = 1'b0;
      #1;
      if (k == 0) begin
        n_tests++;
        if (mmu_req !== 1'b1 || mmu_vaddr !== 32'h4000_1000)
          begin n_fail++; $display("FAIL single_d_grant got req %b va %h want 1 40001000", mmu_req, mmu_vaddr); end
      end
      if (mmu_req && !prev) grants++;
      prev = mmu_req;
      if (d_ready && got < 0) got = k;
    end
    n_tests++;
    if (got !== 1 || grants !== 1)
      begin n_fail++; $display("FAIL single_d_ready got cycle %0d grants %0d want 1 1", got, grants); end
    abort_en = 1'b1; lat_min = 0; lat_max = 2;
  endtask

  // Random requesters against a request-level model of the arbitration rules.
  task automatic run_traffic(input int n, input bit hold_both);
    bit pi = 0, pd = 0, pm = 0, pc = 0, stop = 0, comp, exp_req;
    bit eir, eia, edr, eda;
    int owner = 0, age = 0, starve = 0, n_ig = 0, n_dg = 0, n_iw = 0, k = 0;
    apply_reset();
    grant_log.delete();
    while (k < n + 64 && !(stop && !i_req && !d_req && !pm)) begin
      cycle();
      stop = (k >= n);
      if (pc && owner == 1) i_req = 1'b0;
      if (pc && owner == 2) d_req = 1'b0;
      if (!stop && !i_req && (hold_both || $urandom_range(1, 0) == 1)) begin
        i_req = 1'b1; i_vaddr = $urandom;
      end
      if (!stop && !d_req && (hold_both || $urandom_range(1, 0) == 1)) begin
        d_req = 1'b1; d_vaddr = $urandom; d_write = 1'($urandom); d_size = 2'($urandom); d_wdata = $urandom;
      end
      #1;
      exp_req = pm ? !pc : (pi || pd);
      n_tests++;
      if (mmu_req !== exp_req) begin n_fail++; $display("FAIL traffic_req cycle %0d got %b want %b", k, mmu_req, exp_req); end
      if (mmu_req && !pm) begin
        owner = (pi && starve == SL) ? 1 : (pd ? 2 : 1);
        age = 1;
        grant_log.push_back(owner);
        if (owner == 1) begin starve = 0; n_ig++; end
        else begin n_dg++; if (pi && starve < SL) starve++; end
        n_tests++;
        if (owner == 1 ? (mmu_vaddr !== i_vaddr || mmu_write !== 1'b0 || mmu_size !== 2'b10)
                       : (mmu_vaddr !== d_vaddr || mmu_write !== d_write || mmu_size !== d_size || mmu_wdata !== d_wdata))
          begin n_fail++; $display("FAIL traffic_grant cycle %0d owner %0d got va %h w %b sz %0d want va %h", k, owner, mmu_vaddr, mmu_write, mmu_size, owner == 1 ? i_vaddr : d_vaddr); end
      end else if (mmu_req) age++;
      comp = mmu_req && age >= 2 && (mmu_ready || mmu_abort);
      eir = comp && owner == 1 && mmu_ready;  eia = comp && owner == 1 && mmu_abort;
      edr = comp && owner == 2 && mmu_ready;  eda = comp && owner == 2 && mmu_abort;
      n_tests++;
      if ({i_ready, i_abort, d_ready, d_abort} !== {eir, eia, edr, eda})
        begin n_fail++; $display("FAIL traffic_done cycle %0d got %b want %b", k, {i_ready, i_abort, d_ready, d_abort}, {eir, eia, edr, eda}); end
      if (comp) begin
        n_tests++;
        if ((owner == 1 ? i_rdata : d_rdata) !== mmu_rdata)
          begin n_fail++; $display("FAIL traffic_rdata cycle %0d got %h want %h", k, owner == 1 ? i_rdata : d_rdata, mmu_rdata); end
      end
      if (i_req && !(mmu_req && owner == 1)) n_iw++;
      pi = i_req; pd = d_req; pm = mmu_req; pc = comp;
      k++;
    end
    n_tests++;
    if (!(stop && !i_req && !d_req && !pm)) begin n_fail++; $display("FAIL traffic_drain got busy after %0d cycles want idle", k); end
`ifdef MMU_ARB_STATS_EN
    n_tests++;
    if (stat_i_grants !== 32'(n_ig) || stat_d_grants !== 32'(n_dg) || stat_i_wait !== 32'(n_iw))
      begin n_fail++; $display("FAIL traffic_stats got %0d %0d %0d want %0d %0d %0d", stat_i_grants, stat_d_grants, stat_i_wait, n_ig, n_dg, n_iw); end
`else
    n_tests++;
    if ({stat_i_grants, stat_d_grants, stat_i_wait} !== 96'h0)
      begin n_fail++; $display("FAIL traffic_stats got %0d %0d %0d want 0 0 0", stat_i_grants, stat_d_grants, stat_i_wait); end
`endif
  endtask

  task automatic test_starvation();
    bit ok = 1'b1;
    abort_en = 1'b0;
    run_traffic(150, 1'b1);
    if (grant_log.size() < 20) ok = 1'b0;
    else for (int j = 0; j < 20; j++) if (grant_log[j] != ((j % 5 == 4) ? 1 : 2)) ok = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL starve_order got %0d grants (first %p) want D,D,D,D,I repeating", grant_log.size(), grant_log[0:4]); end
    abort_en = 1'b1;
  endtask

  task automatic test_random();
    run_traffic(400, 1'b0);
    lat_min = 1; lat_max = 4;
    run_traffic(400, 1'b0);
    lat_min = 0; lat_max = 2;
  endtask

  task automatic do_maint(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] asid,
                          input int busy_n, input bit exp_err);
    int cnt[4];
    int ack_k = -1;
    bit err = 1'b0, vals_ok = 1'b1;
    logic [7:0] asid_before, exp_asid;
    asid_before = current_asid;
    for (int j = 0; j < 4; j++) cnt[j] = 0;
    cycle();
    maint_valid = 1'b1; maint_op = op; maint_addr = addr; maint_asid = asid;
    #1;
    for (int k = 0; k < 24 && ack_k < 0; k++) begin
      cycle();
      #1;
      if (tlb_flush_all)    cnt[0]++;
      if (tlb_flush_entry)  cnt[1]++;
      if (tlb_flush_asid)   cnt[2]++;
      if (tlb_flush_global) cnt[3]++;
      if ((tlb_flush_all || tlb_flush_entry || tlb_flush_asid || tlb_flush_global) &&
          (tlb_flush_addr !== addr || tlb_flush_asid_val !== asid)) vals_ok = 1'b0;
      if (k == 0) busy_left = busy_n;
      if (maint_ack) begin ack_k = k; err = maint_err; end
    end
    cycle();
    maint_valid = 1'b0;
    #1;
    n_tests++;
    if (ack_k !== busy_n + 1) begin n_fail++; $display("FAIL maint_ack_time op %0d got %0d want %0d", op, ack_k, busy_n + 1); end
    n_tests++;
    if (err !== exp_err) begin n_fail++; $display("FAIL maint_err op %0d got %b want %b", op, err, exp_err); end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (cnt[j] !== ((32'(op) == j) ? 1 : 0))
        begin n_fail++; $display("FAIL maint_strobe op %0d strobe %0d got %0d pulses want %0d", op, j, cnt[j], (32'(op) == j) ? 1 : 0); end
    end
    n_tests++;
    if (!vals_ok) begin n_fail++; $display("FAIL maint_flush_vals op %0d got %h/%h want %h/%h", op, tlb_flush_addr, tlb_flush_asid_val, addr, asid); end
    exp_asid = (op == 3'd4) ? asid : asid_before;
    n_tests++;
    if (current_asid !== exp_asid) begin n_fail++; $display("FAIL maint_asid op %0d got %h want %h", op, current_asid, exp_asid); end
  endtask

  task automatic test_flush();
    do_maint(FLUSH_ALL, 32'h0, 8'h00, 0, 1'b0);
    do_maint(FLUSH_ENTRY, 32'h8000_3000, 8'h05, 1, 1'b0);
    do_maint(FLUSH_ASID, 32'h0, 8'h01, 3, 1'b0);
    do_maint(FLUSH_GLOBAL, 32'h1234_5000, 8'h00, 0, 1'b0);
  endtask

  task automatic test_reserved();
    do_maint(3'd6, 32'h0, 8'h33, 0, 1'b1);
    do_maint(3'd7, 32'h0, 8'h44, 2, 1'b1);
  endtask

  task automatic test_asid_in_flight();
    int dr = -1, a2 = -1, ack = -1;
    bit bad = 1'b0;
    lat_min = 3; lat_max = 3; abort_en = 1'b0;
    do_maint(SET_ASID, 32'h0, 8'h01, 0, 1'b0);
    cycle();
    d_req = 1'b1; d_vaddr = 32'h0000_8000; d_write = 1'b1; d_size = 2'b01; d_wdata = 32'h55aa;
    #1;
    cycle();
    #1;
    n_tests++;
    if (mmu_req !== 1'b1) begin n_fail++; $display("FAIL asid_flight_grant got %b want 1", mmu_req); end
    maint_valid = 1'b1; maint_op = SET_ASID; maint_asid = 8'h02;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (dr >= 0) d_req = 1'b0;
      if (ack >= 0) maint_valid = 1'b0;
      #1;
      if (mmu_req && current_asid !== 8'h01) bad = 1'b1;
      if (dr < 0 && d_ready) dr = k;
      if (a2 < 0 && current_asid === 8'h02) a2 = k;
      if (ack < 0 && maint_ack) ack = k;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL asid_flight_hold got %h during grant want 01", current_asid); end
    n_tests++;
    if (!(dr >= 0 && a2 > dr && ack >= a2))
      begin n_fail++; $display("FAIL asid_flight_order got ready %0d asid %0d ack %0d want ready<asid<=ack", dr, a2, ack); end
    n_tests++;
    if (current_asid !== 8'h02) begin n_fail++; $display("FAIL asid_flight_final got %h want 02", current_asid); end
    lat_min = 0; lat_max = 2; abort_en = 1'b1;
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    lat_min = 8; lat_max = 8; abort_en = 1'b0;
    cycle();
    i_req = 1'b1; i_vaddr = 32'h0000_2000;
    #1;
    cycle();
    #1;
    n_tests++;
    if (mmu_req !== 1'b1 || mmu_vaddr !== 32'h0000_2000)
      begin n_fail++; $display("FAIL rstmid_grant got %b %h want 1 00002000", mmu_req, mmu_vaddr); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (mmu_req !== 1'b0 || mmu_vaddr !== 32'h0 || mmu_size !== 2'b00)
      begin n_fail++; $display("FAIL rstmid_async got %b %h %0d want 0 0 0", mmu_req, mmu_vaddr, mmu_size); end
    n_tests++;
    if ({stat_i_grants, stat_d_grants, stat_i_wait} !== 96'h0 || current_asid !== 8'h00)
      begin n_fail++; $display("FAIL rstmid_state got %0d %0d %0d asid %h want 0 0 0 00", stat_i_grants, stat_d_grants, stat_i_wait, current_asid); end
    #1;
    rst_n = 1'b1;
    cycle();
    #1;
    n_tests++;
    if (mmu_req !== 1'b1 || mmu_vaddr !== 32'h0000_2000)
      begin n_fail++; $display("FAIL rstmid_restart got %b %h want 1 00002000", mmu_req, mmu_vaddr); end
    apply_reset();
    lat_min = 0; lat_max = 2; abort_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; i_vaddr = '0; d_req = 1'b0; d_vaddr = '0; d_write = 1'b0; d_size = 2'b00; d_wdata = '0;
    maint_valid = 1'b0; maint_op = 3'd0; maint_addr = '0; maint_asid = '0;
    mmu_rdata = '0; mmu_ready = 1'b0; mmu_abort = 1'b0; mmu_busy = 1'b0;
    test_reset();
    test_single_d();
    test_starvation();
    test_random();
    test_flush();
    test_reserved();
    test_asid_in_flight();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
